// File: rtl/t08_lcd_pkg.sv
// Shared opcodes, sequencer states and pixel-count helper for the LCD init/fill sequencer.
package t08_lcd_pkg;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_RAMWRC  = 8'h3C;

  localparam int PIX_W = 17;

  typedef enum logic [3:0] {
    INIT_ISSUE,
    INIT_WAIT,
    INIT_DELAY,
    IDLE,
    CASET,
    PASET,
    RAMWR,
    RAMWRC,
    FINISH
  } state_t;

  // Inclusive rectangle area; corners are already known to be ordered.
  function automatic logic [PIX_W-1:0] pix_count(input logic [8:0] x0, input logic [8:0] x1,
                                                 input logic [8:0] y0, input logic [8:0] y1);
    logic [PIX_W-1:0] w;
    logic [PIX_W-1:0] h;
    w = {8'd0, x1 - x0} + 17'd1;
    h = {8'd0, y1 - y0} + 17'd1;
    return w * h;
  endfunction

endpackage

// File: rtl/t08_lcd_txn.sv
// One downstream bus transaction: latch command/parameters, strobe enable,
// then track busy high and low before signalling completion.
module t08_lcd_txn (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  cmd,
  input  logic [31:0] params,
  input  logic [3:0]  count,
  input  logic        busy,
  output logic [7:0]  command,
  output logic [31:0] parameters,
  output logic [3:0]  counter,
  output logic        enable,
  output logic        txn_done
);

  typedef enum logic [1:0] {TX_IDLE, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;

  tx_state_t   tx_state_r, tx_state_s;
  logic [7:0]  command_r, command_s;
  logic [31:0] parameters_r, parameters_s;
  logic [3:0]  counter_r, counter_s;
  logic        enable_r, enable_s;
  logic        txn_done_r, txn_done_s;

  // Handshake next-state; command fields only change when a new transaction starts.
  always_comb begin
    tx_state_s   = tx_state_r;
    command_s    = command_r;
    parameters_s = parameters_r;
    counter_s    = counter_r;
    enable_s     = 1'b0;
    txn_done_s   = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if (start) begin
          command_s    = cmd;
          parameters_s = params;
          counter_s    = count;
          enable_s     = 1'b1;
          tx_state_s   = TX_WAIT_HI;
        end else begin
          tx_state_s = TX_IDLE;
        end
      end
      TX_WAIT_HI: begin
        if (busy) begin
          tx_state_s = TX_WAIT_LO;
        end else begin
          tx_state_s = TX_WAIT_HI;
        end
      end
      TX_WAIT_LO: begin
        if (!busy) begin
          txn_done_s = 1'b1;
          tx_state_s = TX_IDLE;
        end else begin
          tx_state_s = TX_WAIT_LO;
        end
      end
      default: tx_state_s = TX_IDLE;
    endcase
  end

  // Handshake state and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_r   <= TX_IDLE;
      command_r    <= 8'h00;
      parameters_r <= 32'h0000_0000;
      counter_r    <= 4'd0;
      enable_r     <= 1'b0;
      txn_done_r   <= 1'b0;
    end else begin
      tx_state_r   <= tx_state_s;
      command_r    <= command_s;
      parameters_r <= parameters_s;
      counter_r    <= counter_s;
      enable_r     <= enable_s;
      txn_done_r   <= txn_done_s;
    end
  end

  assign command    = command_r;
  assign parameters = parameters_r;
  assign counter    = counter_r;
  assign enable     = enable_r;
  assign txn_done   = txn_done_r;

endmodule

// File: rtl/t08_lcd_sequencer.sv
// LCD sequencer: runs the panel init sequence after reset, then fills
// rectangles with a solid RGB565 colour through the single transaction engine.
module t08_lcd_sequencer
  import t08_lcd_pkg::*;
#(
  parameter logic [23:0] DELAY_CYCLES = 24'd1_200_000,
  parameter logic [8:0]  H_MAX        = 9'd319,
  parameter logic [8:0]  V_MAX        = 9'd239
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] color,
  input  logic        busy,
  output logic [7:0]  command,
  output logic [31:0] parameters,
  output logic [3:0]  counter,
  output logic        readwrite,
  output logic        enable,
  output logic        init_done,
  output logic        ready,
  output logic        done,
  output logic        err
);

  state_t           state_r, state_s;
  logic             issued_r, issued_s;
  logic [1:0]       init_step_r, init_step_s;
  logic [23:0]      delay_cnt_r, delay_cnt_s;
  logic [8:0]       x0_r, x0_s, x1_r, x1_s, y0_r, y0_s, y1_r, y1_s;
  logic [15:0]      color_r, color_s;
  logic [PIX_W-1:0] remain_r, remain_s;
  logic             init_done_r, init_done_s;
  logic             ready_r, ready_s;
  logic             done_r, done_s;
  logic             err_r, err_s;

  logic             start_s;
  logic [7:0]       cmd_s;
  logic [31:0]      params_s;
  logic [3:0]       count_s;
  logic             txn_done_s;
  logic             req_ok_s;
  logic             two_left_s;

  assign req_ok_s   = (x0 <= x1) && (y0 <= y1) && (x1 <= H_MAX) && (y1 <= V_MAX);
  assign two_left_s = (remain_r >= 17'd2);

  // Sequencer next-state: each transaction state issues once, then advances on txn_done.
  always_comb begin
    state_s     = state_r;
    issued_s    = issued_r;
    init_step_s = init_step_r;
    delay_cnt_s = delay_cnt_r;
    x0_s        = x0_r;
    x1_s        = x1_r;
    y0_s        = y0_r;
    y1_s        = y1_r;
    color_s     = color_r;
    remain_s    = remain_r;
    init_done_s = init_done_r;
    ready_s     = ready_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    start_s     = 1'b0;
    cmd_s       = 8'h00;
    params_s    = 32'h0000_0000;
    count_s     = 4'd0;
    case (state_r)
      INIT_ISSUE: begin
        start_s = 1'b1;
        state_s = INIT_WAIT;
        case (init_step_r)
          2'd0: cmd_s = OP_SWRESET;
          2'd1: cmd_s = OP_SLPOUT;
          2'd2: begin
            cmd_s    = OP_COLMOD;
            params_s = 32'h5500_0000;
            count_s  = 4'd1;
          end
          default: cmd_s = OP_DISPON;
        endcase
      end
      INIT_WAIT: begin
        if (!txn_done_s) begin
          state_s = INIT_WAIT;
        end else if (init_step_r <= 2'd1) begin
          init_step_s = init_step_r + 2'd1;
          delay_cnt_s = DELAY_CYCLES - 24'd1;
          state_s     = INIT_DELAY;
        end else if (init_step_r == 2'd2) begin
          init_step_s = 2'd3;
          state_s     = INIT_ISSUE;
        end else begin
          init_done_s = 1'b1;
          ready_s     = 1'b1;
          state_s     = IDLE;
        end
      end
      INIT_DELAY: begin
        if (delay_cnt_r == 24'd0) begin
          state_s = INIT_ISSUE;
        end else begin
          delay_cnt_s = delay_cnt_r - 24'd1;
        end
      end
      IDLE, FINISH: begin
        state_s = IDLE;
        if (req && ready_r) begin
          if (req_ok_s) begin
            x0_s     = x0;
            x1_s     = x1;
            y0_s     = y0;
            y1_s     = y1;
            color_s  = color;
            remain_s = pix_count(x0, x1, y0, y1);
            ready_s  = 1'b0;
            issued_s = 1'b0;
            state_s  = CASET;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CASET, PASET: begin
        cmd_s    = (state_r == CASET) ? OP_CASET : OP_PASET;
        params_s = (state_r == CASET) ? {7'd0, x0_r, 7'd0, x1_r} : {7'd0, y0_r, 7'd0, y1_r};
        count_s  = 4'd4;
        if (!issued_r) begin
          start_s  = 1'b1;
          issued_s = 1'b1;
        end else if (txn_done_s) begin
          issued_s = 1'b0;
          state_s  = (state_r == CASET) ? PASET : RAMWR;
        end else begin
          state_s = state_r;
        end
      end
      RAMWR, RAMWRC: begin
        cmd_s    = (state_r == RAMWR) ? OP_RAMWR : OP_RAMWRC;
        params_s = two_left_s ? {color_r, color_r} : {color_r, 16'h0000};
        count_s  = two_left_s ? 4'd4 : 4'd2;
        if (!issued_r) begin
          start_s  = 1'b1;
          issued_s = 1'b1;
        end else if (txn_done_s) begin
          issued_s = 1'b0;
          remain_s = remain_r - (two_left_s ? 17'd2 : 17'd1);
          if (remain_r <= 17'd2) begin
            done_s  = 1'b1;
            ready_s = 1'b1;
            state_s = FINISH;
          end else begin
            state_s = RAMWRC;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = INIT_ISSUE;
    endcase
  end

  // Sequencer state and registered status outputs; reset restarts the init sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= INIT_ISSUE;
      issued_r    <= 1'b0;
      init_step_r <= 2'd0;
      delay_cnt_r <= 24'd0;
      x0_r        <= 9'd0;
      x1_r        <= 9'd0;
      y0_r        <= 9'd0;
      y1_r        <= 9'd0;
      color_r     <= 16'h0000;
      remain_r    <= 17'd0;
      init_done_r <= 1'b0;
      ready_r     <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      issued_r    <= issued_s;
      init_step_r <= init_step_s;
      delay_cnt_r <= delay_cnt_s;
      x0_r        <= x0_s;
      x1_r        <= x1_s;
      y0_r        <= y0_s;
      y1_r        <= y1_s;
      color_r     <= color_s;
      remain_r    <= remain_s;
      init_done_r <= init_done_s;
      ready_r     <= ready_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  t08_lcd_txn u_txn (
    .clk        (clk),
    .rst        (rst),
    .start      (start_s),
    .cmd        (cmd_s),
    .params     (params_s),
    .count      (count_s),
    .busy       (busy),
    .command    (command),
    .parameters (parameters),
    .counter    (counter),
    .enable     (enable),
    .txn_done   (txn_done_s)
  );

  assign readwrite = 1'b1;
  assign init_done = init_done_r;
  assign ready     = ready_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_t08_lcd_sequencer.sv
// Directed bench for t08_lcd_sequencer: a bus model holding busy for 3 cycles,
// a transaction log, and hand-computed expected opcodes and parameter words.
module tb_t08_lcd_sequencer;

  logic        clk;
  logic        rst;
  logic        req;
  logic [8:0]  x0, x1, y0, y1;
  logic [15:0] color;
  logic        busy;
  logic [7:0]  command;
  logic [31:0] parameters;
  logic [3:0]  counter;
  logic        readwrite, enable, init_done, ready, done, err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int idle_run = 0;
  logic [7:0]  cmd_q[$];
  logic [31:0] par_q[$];
  logic [3:0]  cnt_q[$];
  int          gap_q[$];

  t08_lcd_sequencer #(.DELAY_CYCLES(24'd10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .color      (color),
    .busy       (busy),
    .command    (command),
    .parameters (parameters),
    .counter    (counter),
    .readwrite  (readwrite),
    .enable     (enable),
    .init_done  (init_done),
    .ready      (ready),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Downstream driver model: busy high for 3 cycles after each enable.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (enable === 1'b1 && rst === 1'b0) begin
        busy = 1'b1;
        repeat (3) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Transaction log, idle-gap measurement, pulse counters and hold check.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst !== 1'b1) begin
        if (enable === 1'b1) begin
          cmd_q.push_back(command);
          par_q.push_back(parameters);
          cnt_q.push_back(counter);
          gap_q.push_back(idle_run);
          idle_run = 0;
        end else if (busy === 1'b0) begin
          idle_run++;
        end
        if (busy === 1'b1 && cmd_q.size() > 0) begin
          check_val("hold_cmd", 32'(command), 32'(cmd_q[cmd_q.size()-1]));
          check_val("hold_par", parameters, par_q[par_q.size()-1]);
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
      end else begin
        idle_run = 0;
      end
    end
  end

  task automatic do_req(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                        input logic [8:0] d, input logic [15:0] col);
    @(negedge clk);
    x0 = a; x1 = b; y0 = c; y1 = d; color = col;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) check_val(tag, 32'(ready), 32'd1);
  endtask

  task automatic wait_en(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (cmd_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (cmd_q.size() < target) check_val(tag, 32'(cmd_q.size()), 32'(target));
  endtask

  task automatic check_txn(input int idx, input logic [7:0] c, input logic [31:0] p,
                           input logic [3:0] n, input string tag);
    if (idx < cmd_q.size()) begin
      check_val({tag, "_cmd"}, 32'(cmd_q[idx]), 32'(c));
      check_val({tag, "_par"}, par_q[idx], p);
      check_val({tag, "_cnt"}, 32'(cnt_q[idx]), 32'(n));
    end else begin
      check_val({tag, "_missing"}, 32'(cmd_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_command"}, 32'(command), 32'd0);
    check_val({tag, "_parameters"}, parameters, 32'd0);
    check_val({tag, "_counter"}, 32'(counter), 32'd0);
    check_val({tag, "_enable"}, 32'(enable), 32'd0);
    check_val({tag, "_init_done"}, 32'(init_done), 32'd0);
    check_val({tag, "_ready"}, 32'(ready), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_err"}, 32'(err), 32'd0);
    check_val({tag, "_readwrite"}, 32'(readwrite), 32'd1);
  endtask

  initial begin
    int base;
    int dbase;
    rst = 1'b0; req = 1'b0;
    x0 = 9'd0; x1 = 9'd0; y0 = 9'd0; y1 = 9'd0; color = 16'h0000;
    #2 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // init sequence, with a stray request while it runs
    wait_en(2, 300, "init_en2_timeout");
    do_req(9'd20, 9'd10, 9'd0, 9'd0, 16'h0000);
    wait_ready(500, "init_timeout");
    check_val("init_done", 32'(init_done), 32'd1);
    check_val("init_ntxn", 32'(cmd_q.size()), 32'd4);
    check_txn(0, 8'h01, 32'h0000_0000, 4'd0, "init0");
    check_txn(1, 8'h11, 32'h0000_0000, 4'd0, "init1");
    check_txn(2, 8'h3A, 32'h5500_0000, 4'd1, "init2");
    check_txn(3, 8'h29, 32'h0000_0000, 4'd0, "init3");
    if (gap_q.size() >= 4) begin
      check_val("gap_after_swreset", 32'(gap_q[1] >= 10), 32'd1);
      check_val("gap_after_slpout", 32'(gap_q[2] >= 10), 32'd1);
      check_val("gap_after_colmod", 32'(gap_q[3] < 10), 32'd1);
    end else begin
      check_val("gap_log", 32'(gap_q.size()), 32'd4);
    end
    check_val("init_no_err", 32'(err_cnt), 32'd0);

    // 2x1 fill in red
    base = cmd_q.size();
    dbase = done_cnt;
    do_req(9'd10, 9'd11, 9'd5, 9'd5, 16'hF800);
    check_val("fill1_ready_drop", 32'(ready), 32'd0);
    wait_ready(300, "fill1_timeout");
    check_val("fill1_done_with_ready", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    check_val("fill1_ntxn", 32'(cmd_q.size() - base), 32'd3);
    check_txn(base + 0, 8'h2A, 32'h000A_000B, 4'd4, "fill1_caset");
    check_txn(base + 1, 8'h2B, 32'h0005_0005, 4'd4, "fill1_paset");
    check_txn(base + 2, 8'h2C, 32'hF800_F800, 4'd4, "fill1_ramwr");
    check_val("fill1_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // 3x1 fill in green, with requests arriving mid-fill
    base = cmd_q.size();
    dbase = done_cnt;
    do_req(9'd0, 9'd2, 9'd0, 9'd0, 16'h07E0);
    repeat (3) @(negedge clk);
    do_req(9'd20, 9'd10, 9'd0, 9'd0, 16'h0000);
    do_req(9'd1, 9'd1, 9'd1, 9'd1, 16'h1111);
    wait_ready(300, "fill2_timeout");
    repeat (10) @(negedge clk);
    check_val("fill2_ntxn", 32'(cmd_q.size() - base), 32'd4);
    check_txn(base + 0, 8'h2A, 32'h0000_0002, 4'd4, "fill2_caset");
    check_txn(base + 1, 8'h2B, 32'h0000_0000, 4'd4, "fill2_paset");
    check_txn(base + 2, 8'h2C, 32'h07E0_07E0, 4'd4, "fill2_ramwr");
    check_txn(base + 3, 8'h3C, 32'h07E0_0000, 4'd2, "fill2_ramwrc");
    check_val("fill2_done_cnt", 32'(done_cnt - dbase), 32'd1);
    check_val("fill2_no_err", 32'(err_cnt), 32'd0);

    // rejections
    base = cmd_q.size();
    do_req(9'd20, 9'd10, 9'd0, 9'd0, 16'hFFFF);
    check_val("rej_x_err", 32'(err), 32'd1);
    check_val("rej_x_ready", 32'(ready), 32'd1);
    do_req(9'd0, 9'd0, 9'd0, 9'd240, 16'hFFFF);
    check_val("rej_y_err", 32'(err), 32'd1);
    check_val("rej_y_ready", 32'(ready), 32'd1);
    do_req(9'd0, 9'd320, 9'd0, 9'd0, 16'hFFFF);
    check_val("rej_hmax_err", 32'(err), 32'd1);
    repeat (20) @(negedge clk);
    check_val("rej_no_txn", 32'(cmd_q.size() - base), 32'd0);
    check_val("rej_err_cnt", 32'(err_cnt), 32'd3);
    check_val("rej_ready_kept", 32'(ready), 32'd1);

    // single pixel at the far corner
    base = cmd_q.size();
    dbase = done_cnt;
    do_req(9'd319, 9'd319, 9'd239, 9'd239, 16'hABCD);
    wait_ready(300, "pix1_timeout");
    repeat (3) @(negedge clk);
    check_val("pix1_ntxn", 32'(cmd_q.size() - base), 32'd3);
    check_txn(base + 0, 8'h2A, 32'h013F_013F, 4'd4, "pix1_caset");
    check_txn(base + 1, 8'h2B, 32'h00EF_00EF, 4'd4, "pix1_paset");
    check_txn(base + 2, 8'h2C, 32'hABCD_0000, 4'd2, "pix1_ramwr");
    check_val("pix1_done_cnt", 32'(done_cnt - dbase), 32'd1);

    // reset while the 0x2B transaction is on the bus
    base = cmd_q.size();
    do_req(9'd0, 9'd1, 9'd0, 9'd1, 16'h1234);
    wait_en(base + 2, 200, "mid_paset_timeout");
    @(negedge clk);
    check_val("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (8) @(negedge clk);
    base = cmd_q.size();
    rst = 1'b0;
    wait_en(base + 1, 100, "restart_timeout");
    check_txn(base, 8'h01, 32'h0000_0000, 4'd0, "restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
